// File: rtl/ahb_apb_pkg.sv
// Shared constants and types for the AHB-Lite to APB4 bridge.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ahb_apb_pkg;

    // Bridge FSM encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_ERR1   = 3'd3;
    localparam logic [2:0] ST_ERR2   = 3'd4;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP encodings (bit 1 is never driven high by this slave)
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // HSIZE encodings supported on a 32-bit bus
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // APB control captured with the address phase and held until the next legal transfer
    typedef struct packed {
        logic       write;
        logic [3:0] strb;
        logic [2:0] prot;
    } apb_ctl_t;

    // PPROT = {instruction, secure, privileged}; HPROT[0]=1 means data access
    function automatic logic [2:0] ahb_to_pprot(input logic [3:0] hprot);
        return {~hprot[0], 1'b0, hprot[1]};
    endfunction

endpackage

// File: rtl/ahb_apb_strb_decode.sv
// Maps AHB size/low address/direction to APB byte strobes and flags illegal size or alignment.
// Latency: purely combinational.
// Backpressure: none; consumed only on the accept cycle.
module ahb_apb_strb_decode
    import ahb_apb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    input  logic       hwrite,
    output logic [3:0] strb,
    output logic       illegal
);

    logic [3:0] lanes;

    // Byte-lane decode; reads always drive zero strobes
    always_comb begin
        lanes   = 4'b0000;
        illegal = 1'b0;
        case (hsize)
            HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                lanes   = addr_lo[1] ? 4'b1100 : 4'b0011;
                illegal = addr_lo[0];
            end
            HSIZE_WORD: begin
                lanes   = 4'b1111;
                illegal = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        strb = (hwrite && !illegal) ? lanes : 4'b0000;
    end

endmodule

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB SETUP/ACCESS per selected AHB transfer.
// Latency: 2 AHB wait states minimum, plus one per PREADY-low ACCESS cycle; errors take two cycles.
// Backpressure: HREADYOUT low from SETUP until APB completion; new transfers accepted only in IDLE/ERR2.
module ahb_to_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [3:0]            HPROT,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [31:0]           HRDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
    input  logic                  PREADY,
    input  logic [31:0]           PRDATA,
    input  logic                  PSLVERR
);

    logic [2:0]            state_q;
    logic [2:0]            state_d;
    logic                  accept;
    logic                  can_accept;
    logic                  illegal;
    logic [3:0]            strb_dec;
    logic                  psel_q;
    logic                  penable_q;
    logic                  hreadyout_q;
    logic [1:0]            hresp_q;
    logic [31:0]           hrdata_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    apb_ctl_t              ctl_q;
    logic                  unused_inputs;

    // Upper address bits, HTRANS[0] (SEQ vs NONSEQ) and cacheable/bufferable HPROT bits have no APB meaning
    assign unused_inputs = &{1'b0, HADDR[31:ADDR_WIDTH], HTRANS[0], HPROT[3:2]};

    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign accept     = can_accept && HSEL && HTRANS[1] && HREADY;

    ahb_apb_strb_decode u_strb_decode (
        .hsize   (HSIZE),
        .addr_lo (HADDR[1:0]),
        .hwrite  (HWRITE),
        .strb    (strb_dec),
        .illegal (illegal)
    );

    // Next-state decode of the transfer sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    state_d = illegal ? ST_ERR1 : ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d = PSLVERR ? ST_ERR1 : ST_IDLE;
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State plus bus handshake outputs, all decoded from the next state so they leave flops directly
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
            penable_q   <= (state_d == ST_ACCESS);
            hreadyout_q <= !((state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_ERR1));
            hresp_q     <= ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

    // Capture the address phase of legal transfers; illegal ones leave the APB lines untouched
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            paddr_q <= '0;
            ctl_q   <= '0;
        end else if (accept && !illegal) begin
            paddr_q <= {HADDR[ADDR_WIDTH-1:2], 2'b00};
            ctl_q   <= '{write: HWRITE, strb: strb_dec, prot: ahb_to_pprot(HPROT)};
        end
    end

    // Read data is latched only on a successful read completion, otherwise held
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hrdata_q <= '0;
        end else if ((state_q == ST_ACCESS) && PREADY && !PSLVERR && !ctl_q.write) begin
            hrdata_q <= PRDATA;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = ctl_q.write;
    assign PSTRB     = ctl_q.strb;
    assign PPROT     = ctl_q.prot;
    // HWDATA is held by the master for the whole data phase, so it is valid from SETUP onward
    assign PWDATA    = HWDATA;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Scoreboard bench for ahb_to_apb_bridge: directed AHB transfers against an APB slave model.
// Latency: checks wait-state counts per transfer and SETUP timing for back-to-back traffic.
// Backpressure: the single-slave bus ties HREADY to HREADYOUT.
module tb_ahb_to_apb_bridge;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic        PSEL;
    logic        PENABLE;
    logic [15:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    ahb_to_apb_bridge #(.ADDR_WIDTH(16)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR)
    );

    // Single slave on the bus: the bus-level ready is this slave's ready
    assign HREADY = HREADYOUT;

    typedef struct {
        logic [1:0]  hresp;
        logic        chk;
        logic [31:0] rdata;
        int          waits;
        int          id;
    } resp_t;

    typedef struct {
        logic [15:0] paddr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [2:0]  prot;
        int          id;
    } apb_t;

    typedef struct {
        int          waits;
        logic [31:0] rdata;
        logic        err;
    } slv_t;

    resp_t resp_q[$];
    apb_t  apb_q[$];
    slv_t  slv_q[$];
    int    setup_cyc[$];
    int    done_cyc[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        forever begin
            @(posedge HCLK);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // APB slave model: pops one response per ACCESS phase and drives it after its wait count
    initial begin
        slv_t cur;
        int   wc;
        bit   in_acc;
        cur    = '{0, 32'h0, 1'b0};
        wc     = 0;
        in_acc = 0;
        PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
        forever begin
            @(posedge HCLK);
            #2;
            if (PSEL && PENABLE) begin
                if (!in_acc) begin
                    in_acc = 1;
                    wc     = 0;
                    if (slv_q.size() != 0) cur = slv_q.pop_front();
                    else cur = '{0, 32'h0, 1'b0};
                end
                if (wc >= cur.waits) begin
                    PREADY = 1'b1; PRDATA = cur.rdata; PSLVERR = cur.err;
                end else begin
                    PREADY = 1'b0; PRDATA = 32'hBAD0_BAD0; PSLVERR = 1'b0;
                end
                wc++;
            end else begin
                in_acc = 0;
                PREADY = 1'b0; PSLVERR = 1'b0;
            end
        end
    end

    // AHB response monitor: counts wait states of each data phase and compares at completion
    initial begin
        bit          pending;
        int          waits;
        logic [1:0]  wait_hresp;
        resp_t       e;
        pending    = 0;
        waits      = 0;
        wait_hresp = 2'b00;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                pending = 0;
            end else begin
                if (pending) begin
                    if (HREADYOUT) begin
                        if (resp_q.size() == 0) begin
                            fail_now("unexpected_ahb_completion");
                        end else begin
                            e = resp_q.pop_front();
                            check($sformatf("t%0d_hresp", e.id), {30'h0, HRESP}, {30'h0, e.hresp});
                            check($sformatf("t%0d_waits", e.id), waits, e.waits);
                            check($sformatf("t%0d_wait_hresp", e.id), {30'h0, wait_hresp}, {30'h0, e.hresp});
                            if (e.chk) check($sformatf("t%0d_hrdata", e.id), HRDATA, e.rdata);
                            done_cyc.push_back(cyc);
                        end
                        pending = 0;
                    end else begin
                        waits++;
                        wait_hresp = HRESP;
                    end
                end
                if (HSEL && HTRANS[1] && HREADY) begin
                    pending = 1;
                    waits   = 0;
                end
            end
        end
    end

    // APB request monitor: every PSEL cycle must match the oldest expected access
    initial begin
        apb_t a;
        int   apb_cnt;
        apb_cnt = 0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                apb_cnt = 0;
            end else if (PSEL) begin
                if (apb_q.size() == 0) begin
                    fail_now($sformatf("unexpected_psel paddr=0x%04h", PADDR));
                end else begin
                    a = apb_q[0];
                    check($sformatf("t%0d_paddr", a.id), {16'h0, PADDR}, {16'h0, a.paddr});
                    check($sformatf("t%0d_pwrite", a.id), {31'h0, PWRITE}, {31'h0, a.wr});
                    check($sformatf("t%0d_pstrb", a.id), {28'h0, PSTRB}, {28'h0, a.strb});
                    check($sformatf("t%0d_pprot", a.id), {29'h0, PPROT}, {29'h0, a.prot});
                    check($sformatf("t%0d_penable", a.id), {31'h0, PENABLE}, {31'h0, (apb_cnt != 0)});
                    if (a.wr) check($sformatf("t%0d_pwdata", a.id), PWDATA, a.wdata);
                    if (apb_cnt == 0) setup_cyc.push_back(cyc);
                    apb_cnt++;
                    if (PENABLE && PREADY) begin
                        void'(apb_q.pop_front());
                        apb_cnt = 0;
                    end
                end
            end
        end
    end

    // Present one address phase, hold it until accepted, then move into its data phase
    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] s,
                         input logic [31:0] d, input logic [3:0] p);
        int n;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = s; HPROT = p;
        n = 0;
        @(negedge HCLK);
        while (!HREADY && n < 64) begin
            @(negedge HCLK);
            n++;
        end
        if (!HREADY) fail_now("issue_timeout");
        @(posedge HCLK);
        #1;
        HWDATA = d;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || apb_q.size() != 0) && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        if (resp_q.size() != 0 || apb_q.size() != 0) fail_now("drain_timeout");
        resp_q.delete();
        apb_q.delete();
        repeat (2) @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET = 1'b1;
        HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HSIZE = 3'b010;
        HWRITE = 1'b0; HPROT = 4'b0011; HWDATA = 32'h0;

        // Reset state
        #12;
        check("rst_hreadyout", {31'h0, HREADYOUT}, 32'd1);
        check("rst_hresp",     {30'h0, HRESP},     32'd0);
        check("rst_hrdata",    HRDATA,             32'h0);
        check("rst_psel",      {31'h0, PSEL},      32'd0);
        check("rst_penable",   {31'h0, PENABLE},   32'd0);
        check("rst_paddr",     {16'h0, PADDR},     32'h0);
        check("rst_pwrite",    {31'h0, PWRITE},    32'd0);
        check("rst_pstrb",     {28'h0, PSTRB},     32'd0);
        check("rst_pprot",     {29'h0, PPROT},     32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        repeat (2) @(posedge HCLK); #1;

        // t1: word write, zero APB waits
        apb_q.push_back('{16'h1004, 1'b1, 4'b1111, 32'hDEAD_BEEF, 3'b001, 1});
        slv_q.push_back('{0, 32'h0, 1'b0});
        resp_q.push_back('{2'b00, 1'b1, 32'h0, 2, 1});
        issue(32'h0000_1004, 1'b1, 3'b010, 32'hDEAD_BEEF, 4'b0011);
        drain();

        // t2: word read, PREADY low for three ACCESS cycles
        apb_q.push_back('{16'h0010, 1'b0, 4'b0000, 32'h0, 3'b100, 2});
        slv_q.push_back('{3, 32'h1234_5678, 1'b0});
        resp_q.push_back('{2'b00, 1'b1, 32'h1234_5678, 5, 2});
        issue(32'h0000_0010, 1'b0, 3'b010, 32'h0, 4'b0000);
        drain();

        // t3: byte write to lane 3, HRDATA held
        apb_q.push_back('{16'h0200, 1'b1, 4'b1000, 32'hAA00_0000, 3'b000, 3});
        slv_q.push_back('{0, 32'h0, 1'b0});
        resp_q.push_back('{2'b00, 1'b1, 32'h1234_5678, 2, 3});
        issue(32'h0000_0203, 1'b1, 3'b000, 32'hAA00_0000, 4'b0001);
        drain();

        // t4: upper halfword write
        apb_q.push_back('{16'h0200, 1'b1, 4'b1100, 32'hBEEF_0000, 3'b101, 4});
        slv_q.push_back('{0, 32'h0, 1'b0});
        resp_q.push_back('{2'b00, 1'b1, 32'h1234_5678, 2, 4});
        issue(32'h0000_0202, 1'b1, 3'b001, 32'hBEEF_0000, 4'b0010);
        drain();

        // t5: byte read, one wait, strobes zero
        apb_q.push_back('{16'h0200, 1'b0, 4'b0000, 32'h0, 3'b001, 5});
        slv_q.push_back('{1, 32'hCAFE_F00D, 1'b0});
        resp_q.push_back('{2'b00, 1'b1, 32'hCAFE_F00D, 3, 5});
        issue(32'h0000_0201, 1'b0, 3'b000, 32'h0, 4'b0011);
        drain();

        // t6: read answered with PSLVERR -> two-cycle ERROR, HRDATA unchanged
        apb_q.push_back('{16'h0040, 1'b0, 4'b0000, 32'h0, 3'b001, 6});
        slv_q.push_back('{0, 32'h5555_5555, 1'b1});
        resp_q.push_back('{2'b01, 1'b1, 32'hCAFE_F00D, 3, 6});
        issue(32'h0000_0040, 1'b0, 3'b010, 32'h0, 4'b0011);
        drain();

        // t7: misaligned word, no APB access
        resp_q.push_back('{2'b01, 1'b1, 32'hCAFE_F00D, 1, 7});
        issue(32'h0000_0002, 1'b1, 3'b010, 32'h1111_1111, 4'b0011);
        drain();

        // t8: HSIZE wider than the bus, no APB access
        resp_q.push_back('{2'b01, 1'b1, 32'hCAFE_F00D, 1, 8});
        issue(32'h0000_0000, 1'b0, 3'b011, 32'h0, 4'b0011);
        drain();

        // t9/t10: misaligned halfword, then a write accepted during ERR2
        resp_q.push_back('{2'b01, 1'b1, 32'hCAFE_F00D, 1, 9});
        apb_q.push_back('{16'h0008, 1'b1, 4'b1111, 32'h0102_0304, 3'b001, 10});
        slv_q.push_back('{0, 32'h0, 1'b0});
        resp_q.push_back('{2'b00, 1'b1, 32'hCAFE_F00D, 2, 10});
        issue(32'h0000_0001, 1'b1, 3'b001, 32'h0, 4'b0011);
        issue(32'h0000_0008, 1'b1, 3'b010, 32'h0102_0304, 4'b0011);
        drain();

        // t11/t12: back-to-back write then read
        setup_cyc.delete();
        done_cyc.delete();
        apb_q.push_back('{16'h0100, 1'b1, 4'b1111, 32'h0A0B_0C0D, 3'b001, 11});
        slv_q.push_back('{0, 32'h0, 1'b0});
        resp_q.push_back('{2'b00, 1'b1, 32'hCAFE_F00D, 2, 11});
        apb_q.push_back('{16'h0104, 1'b0, 4'b0000, 32'h0, 3'b001, 12});
        slv_q.push_back('{0, 32'hA5A5_A5A5, 1'b0});
        resp_q.push_back('{2'b00, 1'b1, 32'hA5A5_A5A5, 2, 12});
        issue(32'h0000_0100, 1'b1, 3'b010, 32'h0A0B_0C0D, 4'b0011);
        issue(32'h0000_0104, 1'b0, 3'b010, 32'h0, 4'b0011);
        drain();
        if (setup_cyc.size() >= 2 && done_cyc.size() >= 1)
            check("b2b_setup_after_done", setup_cyc[1], done_cyc[0] + 1);
        else
            fail_now("b2b_cycle_log_missing");

        // t13: reset asserted during ACCESS drops the APB handshake immediately
        apb_q.push_back('{16'h0020, 1'b0, 4'b0000, 32'h0, 3'b001, 13});
        slv_q.push_back('{5, 32'h7777_7777, 1'b0});
        resp_q.push_back('{2'b00, 1'b0, 32'h0, 0, 13});
        issue(32'h0000_0020, 1'b0, 3'b010, 32'h0, 4'b0011);
        @(posedge HCLK); #1;
        check("pre_rst_penable", {31'h0, PENABLE}, 32'd1);
        #2;
        HRESET = 1'b1;
        #1;
        check("async_rst_psel",      {31'h0, PSEL},      32'd0);
        check("async_rst_penable",   {31'h0, PENABLE},   32'd0);
        check("async_rst_hreadyout", {31'h0, HREADYOUT}, 32'd1);
        check("async_rst_hresp",     {30'h0, HRESP},     32'd0);
        repeat (2) @(posedge HCLK); #1;
        resp_q.delete();
        apb_q.delete();
        slv_q.delete();
        check("async_rst_hrdata", HRDATA, 32'h0);
        check("async_rst_paddr",  {16'h0, PADDR}, 32'h0);
        HRESET = 1'b0;
        repeat (2) @(posedge HCLK); #1;

        // t14: normal operation after reset
        apb_q.push_back('{16'h0008, 1'b1, 4'b1111, 32'h0BAD_F00D, 3'b001, 14});
        slv_q.push_back('{0, 32'h0, 1'b0});
        resp_q.push_back('{2'b00, 1'b1, 32'h0, 2, 14});
        issue(32'h0000_0008, 1'b1, 3'b010, 32'h0BAD_F00D, 4'b0011);
        drain();

        check("resp_q_empty", resp_q.size(), 0);
        check("slv_q_empty",  slv_q.size(),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
